pipeline_cis_subtractor: RTL and testbench
==========================================

# pipeline_cis_subtractor

Registered, pipelined carry-increment subtractor computing `diff = a - b - bin` over WIDTH bits, with a borrow-out and a valid/ready handshake on both sides. It is the subtract-direction counterpart of the pipelined carry-increment adder path, and it sits inside the same timing-wrapper style: an input register, then STAGES block stages, then an output register. Unlike the adder wrapper, it carries valid flags and supports back-pressure, so it can sit inside a stream datapath.

## Interface
- `WIDTH`, 64: operand width in bits. Must be divisible by `STAGES`.
- `STAGES`, 4: number of carry-increment block stages. Block width is `WIDTH/STAGES`.
- `clk`  in  1: the only clock. All logic is rising-edge.
- `rst`  in  1: reset. Synchronous and active-high.
- `in_valid`  in  1: the input beat is present.
- `in_ready`  out  1: the block can accept a beat this cycle.
- `a`  in  WIDTH: minuend, unsigned or two's complement.
- `b`  in  WIDTH: subtrahend.
- `bin`  in  1: borrow-in.
- `out_valid`  out  1: the result beat is present.
- `out_ready`  in  1: the downstream side accepts the beat.
- `diff`  out  WIDTH: `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: borrow-out. Equals 1 when `a < b + bin` (unsigned comparison).
- `ovf`  out  1: signed overflow. See Configuration.

## Operation
- The block computes `a + ~b + ~bin` with the carry-increment scheme. `bout` is the inverted final carry.
- Stage k handles bits `[k*BW +: BW]`, where `BW = WIDTH/STAGES`:
  - It forms both block sums, with carry 0 and with carry 1.
  - It selects between them using the incoming block carry.
  - It registers the completed low bits, the still-pending upper operand bits, and the block carry-out.
- Each beat's valid bit travels with it through every register level: the input register, the STAGES stages, and the output register.
- The whole pipeline uses one global advance: `adv = !out_valid || out_ready`. When `adv` is 1, every register level shifts.
- `in_ready = adv`. A beat is accepted when `in_valid && in_ready`.
- Bubbles are not squeezed out. An empty level still waits for `adv`.
- When `adv` is 0 the pipeline is held:
  - All registers hold their values.
  - `diff`, `bout` and `ovf` stay stable while `out_valid` is high.
- A beat is consumed on a cycle with `out_valid && out_ready`. A new beat may enter in the same cycle.
- Register contents are don't-care when the matching valid bit is 0. They are still reset.
- Elaboration fails if `WIDTH % STAGES != 0` or if `STAGES < 1`.

## Timing
- Latency is `L = STAGES + 2` cycles with no stall. A beat accepted in cycle 0 has `out_valid` high in cycle L. The default L is 6.
- Throughput is one beat per cycle while `out_ready` stays high.
- Reset, in a cycle where `rst` is high at the edge:
  - All valid bits clear. `out_valid` is 0 from the next cycle.
  - `diff` = 0, `bout` = 0, `ovf` = 0.
  - `in_ready` reads 1 after reset, because `out_valid` is 0.
- Reset during operation drops every in-flight beat with no partial output. Reset takes priority over `adv`.
- Stall: if `out_ready` is low while `out_valid` is high, nothing moves. The pipeline accepts up to L beats before `in_ready` falls.
- Simultaneous consume and accept is allowed: `out_ready=1` and `in_valid=1` in the same cycle give a full-rate shift.

## Configuration
- Macro `PIPELINE_CIS_SUB_OVF_EN`.
- When it is defined:
  - `ovf` equals the signed overflow of the subtraction: `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`.
  - The operand MSBs are piped alongside each beat.
  - `ovf` is registered with `diff` and has the same latency.
- When it is undefined:
  - The `ovf` port still exists and is tied to 0.
  - No MSB pipeline registers are generated.

## Structure
- Package `cis_sub_pkg` holds:
  - the default width and stage constants;
  - a function computing the block width;
  - a typedef for the per-stage payload struct: pending `a`/`b`, completed `diff`, carry, and the optional MSBs.
- One sub-module, `cis_block_stage`, is natural. It is one BW-wide carry-increment select block plus its payload register, with valid and enable inputs. It is instantiated STAGES times with a generate loop.
- The input and output registers are plain enable registers in the top level.

## Test plan
- `a=5`, `b=3`, `bin=0`, `out_ready=1` → after 6 cycles `diff=2`, `bout=0`, `ovf=0`.
- `a=0`, `b=1`, `bin=0` → `diff=0xFFFF_FFFF_FFFF_FFFF`, `bout=1`. Separately, `a=0`, `b=0`, `bin=1` gives the same result.
- `a=0x8000_0000_0000_0000`, `b=1` with the macro defined → `diff=0x7FFF_FFFF_FFFF_FFFF`, `ovf=1`, `bout=0`. With the macro undefined, `ovf` stays 0.
- Back-to-back stream of 10 beats with `out_ready` held low from cycle 3 to cycle 9:
  - `in_ready` falls once 6 beats are inside.
  - The outputs hold stable during the stall.
  - All 10 results come out in order, with none lost or duplicated.
- `rst` asserted while 4 beats are in flight → `out_valid=0` from the next cycle, `diff=0`, `bout=0`, and no stale beat appears afterwards.
- Carry across block boundaries: `a=0x0000_0000_0001_0000`, `b=1` → `diff=0x0000_0000_0000_FFFF`, `bout=0`.

Source files
------------

// File: rtl/pipeline_cis_subtractor_pkg.sv
// cis_sub_pkg: shared constants, block-width helper and per-stage flag payload.
// Flag payload carries operand MSBs only when PIPELINE_CIS_SUB_OVF_EN is defined.
package cis_sub_pkg;
    localparam int CIS_WIDTH  = 64;
    localparam int CIS_STAGES = 4;
    function automatic int blk_w(input int w, input int s);
        return (s < 1) ? w : w / s;
    endfunction
    typedef struct packed {
        logic c;
`ifdef PIPELINE_CIS_SUB_OVF_EN
        logic a_msb;
        logic b_msb;
`endif
    } cis_flags_t;
endpackage

// File: rtl/pipeline_cis_subtractor_stage.sv
// cis_block_stage: one BW-wide carry-increment select block of a + ~b with its payload register.
module cis_block_stage import cis_sub_pkg::*; #(
    parameter int WIDTH = CIS_WIDTH,
    parameter int BW    = 16,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             v_i,
    input  logic [BW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    input  logic [WIDTH-1:0] d_i,
    input  cis_flags_t       f_i,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o,
    output cis_flags_t       f_o
);
    logic [BW:0] s0, s1, sel;
    logic [WIDTH-1:0] d_d, d_q;
    cis_flags_t f_d, f_q;
    logic v_q;
    // d_i is zero in this block's slice, so OR-ing the selected sum completes it
    always_comb begin
        s0 = {1'b0, a_i} + {1'b0, ~b_i};
        s1 = s0 + (BW+1)'(1);
        sel = f_i.c ? s1 : s0;
        d_d = d_i | (WIDTH'(sel[BW-1:0]) << (K*BW));
        f_d = f_i;
        f_d.c = sel[BW];
    end
    always_ff @(posedge clk)
        if (rst) begin
            v_q <= 1'b0;
            d_q <= '0;
            f_q <= '0;
        end else if (en_i) begin
            v_q <= v_i;
            d_q <= d_d;
            f_q <= f_d;
        end
    assign v_o = v_q;
    assign d_o = d_q;
    assign f_o = f_q;
endmodule

// File: rtl/pipeline_cis_subtractor.sv
// pipeline_cis_subtractor: pipelined carry-increment diff = a - b - bin with valid/ready stalling.
// Define PIPELINE_CIS_SUB_OVF_EN to produce signed overflow on ovf; otherwise ovf is tied 0.
module pipeline_cis_subtractor import cis_sub_pkg::*; #(
    parameter int WIDTH  = CIS_WIDTH,
    parameter int STAGES = CIS_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int BW = blk_w(WIDTH, STAGES);
    if (STAGES < 1 || (WIDTH % ((STAGES < 1) ? 1 : STAGES)) != 0) begin : g_bad
        $error("WIDTH must be a multiple of STAGES and STAGES >= 1");
    end
    logic adv, v_in_q, out_valid_q, bout_q;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    cis_flags_t f_in_d, f_in_q;
    logic vl [0:STAGES];
    logic [WIDTH-1:0] dl [0:STAGES];
    cis_flags_t fl [0:STAGES];
    assign adv = !out_valid_q || out_ready;
    assign in_ready = adv;
    // carry-in of a + ~b + ~bin is the inverted borrow-in
    always_comb begin
        f_in_d = '0;
        f_in_d.c = ~bin;
`ifdef PIPELINE_CIS_SUB_OVF_EN
        f_in_d.a_msb = a[WIDTH-1];
        f_in_d.b_msb = b[WIDTH-1];
`endif
    end
    always_ff @(posedge clk)
        if (rst) begin
            v_in_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            f_in_q <= '0;
        end else if (adv) begin
            v_in_q <= in_valid;
            a_q <= a;
            b_q <= b;
            f_in_q <= f_in_d;
        end
    assign vl[0] = v_in_q;
    assign dl[0] = '0;
    assign fl[0] = f_in_q;
    // each level keeps only the operand bits not yet consumed by earlier blocks
    for (genvar k = 0; k < STAGES; k++) begin : g
        localparam int PW = WIDTH - k*BW;
        logic [PW-1:0] pa_q, pb_q;
        if (k == 0) begin : g_first
            assign pa_q = a_q;
            assign pb_q = b_q;
        end else begin : g_next
            always_ff @(posedge clk)
                if (rst) begin
                    pa_q <= '0;
                    pb_q <= '0;
                end else if (adv) begin
                    pa_q <= g[k-1].pa_q[PW+BW-1:BW];
                    pb_q <= g[k-1].pb_q[PW+BW-1:BW];
                end
        end
        cis_block_stage #(.WIDTH(WIDTH), .BW(BW), .K(k)) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (adv),
            .v_i  (vl[k]),
            .a_i  (pa_q[BW-1:0]),
            .b_i  (pb_q[BW-1:0]),
            .d_i  (dl[k]),
            .f_i  (fl[k]),
            .v_o  (vl[k+1]),
            .d_o  (dl[k+1]),
            .f_o  (fl[k+1])
        );
    end
    always_ff @(posedge clk)
        if (rst) begin
            out_valid_q <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (adv) begin
            out_valid_q <= vl[STAGES];
            diff_q <= dl[STAGES];
            bout_q <= ~fl[STAGES].c;
        end
`ifdef PIPELINE_CIS_SUB_OVF_EN
    logic ovf_q;
    always_ff @(posedge clk)
        if (rst) ovf_q <= 1'b0;
        else if (adv) ovf_q <= (fl[STAGES].a_msb != fl[STAGES].b_msb) && (dl[STAGES][WIDTH-1] != fl[STAGES].a_msb);
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif
    assign out_valid = out_valid_q;
    assign diff = diff_q;
    assign bout = bout_q;
endmodule

// File: tb/tb_pipeline_cis_subtractor.sv
// tb_pipeline_cis_subtractor: directed and random stream checks against an arithmetic scoreboard.
module tb_pipeline_cis_subtractor;
    localparam int W = 64;
    logic clk = 1'b0;
    logic rst = 1'b1, in_valid = 1'b0, bin = 1'b0, out_ready = 1'b1;
    logic [W-1:0] a = '0, b = '0;
    logic in_ready, out_valid, bout, ovf;
    logic [W-1:0] diff;
    typedef struct { logic [W-1:0] d; logic bo; logic ov; } res_t;
    res_t q[$];
    int checks = 0, passed = 0, acc_n = 0, con_n = 0;
    logic hold_v = 1'b0, hold_b = 1'b0, hold_o = 1'b0;
    logic [W-1:0] hold_d = '0;
`ifdef PIPELINE_CIS_SUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    pipeline_cis_subtractor dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] r;
        res_t m;
        r = {1'b0, x} - {1'b0, y} - (W+1)'(c);
        m.d = r[W-1:0];
        m.bo = r[W];
        m.ov = OVF_ON && (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        res_t e;
        #1;
        if (hold_v) begin
            chk("hold_valid", W'(out_valid), 1);
            chk("hold_diff", diff, hold_d);
            chk("hold_bout", W'(bout), W'(hold_b));
            chk("hold_ovf", W'(ovf), W'(hold_o));
        end
        chk("in_ready", W'(in_ready), W'(!out_valid || out_ready));
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_beat", W'(out_valid), 0);
            else begin
                e = q.pop_front();
                con_n++;
                chk("sb_diff", diff, e.d);
                chk("sb_bout", W'(bout), W'(e.bo));
                chk("sb_ovf", W'(ovf), W'(e.ov));
            end
        end
        if (!rst && in_valid && in_ready) begin
            q.push_back(model(a, b, bin));
            acc_n++;
        end
        if (rst) q.delete();
        hold_v = !rst && out_valid && !out_ready;
        hold_d = diff;
        hold_b = bout;
        hold_o = ovf;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input logic [W-1:0] xd, input logic xb, input logic xo, input string tag);
        int n = 0;
        a = x;
        b = y;
        bin = c;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, W'(n + 1), 6);
        chk({tag, "_diff"}, diff, xd);
        chk({tag, "_bout"}, W'(bout), W'(xb));
        chk({tag, "_ovf"}, W'(ovf), W'(xo));
        step();
    endtask

    initial begin
        int n;
        logic fell;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", W'(out_valid), 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", W'(bout), 0);
        chk("rst_ovf", W'(ovf), 0);
        chk("rst_in_ready", W'(in_ready), 1);

        send(64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, "basic");
        send(64'd0, 64'd1, 1'b0, '1, 1'b1, 1'b0, "wrap_b");
        send(64'd0, 64'd0, 1'b1, '1, 1'b1, 1'b0, "wrap_bin");
        send(64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, OVF_ON, "ovf");
        send(64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0, "blk_carry");
        send('1, '1, 1'b1, '1, 1'b1, 1'b0, "max_bin");

        acc_n = 0;
        con_n = 0;
        fell = 1'b0;
        for (int c = 0; c < 60 && con_n < 10; c++) begin
            in_valid = acc_n < 10;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            bin = 1'($urandom_range(0, 1));
            out_ready = !(c >= 3 && c <= 9);
            #1;
            if (!in_ready && !fell) begin
                fell = 1'b1;
                chk("stall_inside", W'(acc_n - con_n), 6);
            end
            step();
        end
        in_valid = 1'b0;
        chk("stall_fell", W'(fell), 1);
        chk("stall_consumed", W'(con_n), 10);
        chk("stall_accepted", W'(acc_n), 10);

        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            a = (i % 7 == 0) ? {32'h0, $urandom} : {$urandom, $urandom};
            b = (i % 5 == 0) ? a : {$urandom, $urandom};
            bin = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_empty", W'(q.size()), 0);

        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_valid", W'(out_valid), 0);
        chk("flush_diff", diff, 0);
        chk("flush_bout", W'(bout), 0);
        chk("flush_ovf", W'(ovf), 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid) n++;
        end
        chk("flush_no_stale", W'(n), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
